uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10417, meaning clock cycles per bit period (9600 baud at 100 MHz); legal range 4..65535.
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is on the rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port rx, input, 1, asynchronous serial line; it idles high.
REQ-005 SHALL have port data, output, 8, last correctly framed byte received; held until the next valid frame.
REQ-006 SHALL have port rx_done, output, 1, single-cycle pulse marking that data has just been updated.
REQ-007 SHALL have port frame_err, output, 1, single-cycle pulse marking that the stop bit was sampled low.

Function
REQ-008 SHALL pass rx through a 2-flop synchronizer, giving rx_s; all decisions use rx_s only (2-cycle input latency).
REQ-009 SHALL frame as 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), with no parity.
REQ-010 SHALL implement the states IDLE, START, DATA, STOP and WAIT_IDLE, using a 16-bit cycle counter and a 3-bit bit index.
REQ-011 IDLE: on rx_s==0, SHALL clear the counter and go to START.
REQ-012 START: at counter==CLKS_PER_BIT/2-1 (integer division), SHALL go to DATA with counter and bit index cleared if rx_s==0, else return to IDLE (glitch reject).
REQ-013 DATA: at counter==CLKS_PER_BIT-1, SHALL store rx_s into shift[bit_index], clear the counter and increment the bit index; after bit index 7 is stored it SHALL go to STOP.
REQ-014 STOP: at counter==CLKS_PER_BIT-1, if rx_s==1 SHALL load data from the shift register, pulse rx_done and go to IDLE.
REQ-015 STOP: at counter==CLKS_PER_BIT-1, if rx_s==0 SHALL pulse frame_err, leave data unchanged, not pulse rx_done, and go to WAIT_IDLE.
REQ-016 WAIT_IDLE: SHALL go to IDLE on the first cycle with rx_s==1, so a held-low line (break) yields exactly one frame_err.
REQ-017 In every state other than the sample cycles, SHALL increment the counter by 1; the counter never wraps.
REQ-018 SHALL sample every bit at its nominal centre, tolerating ±4% baud mismatch.
REQ-019 SHALL assert rx_done and frame_err for exactly one cycle and never in the same cycle.
REQ-020 SHALL accept a start edge on the cycle immediately after returning to IDLE (back-to-back frames, no idle gap required).

Reset
REQ-021 While reset is high at a clk edge, SHALL set state=IDLE, counter=0, bit index=0, shift=0, data=8'h00, rx_done=0, frame_err=0, synchronizer flops=1.
REQ-022 Reset asserted mid-frame SHALL abandon the frame with no rx_done or frame_err; reception resumes with the next start bit after release.

Structure
REQ-023 Package uart_pkg SHALL hold the state encoding and the default CLKS_PER_BIT constants (9600 baud: 10417; 115200 baud: 868), shared with the transmitter.
REQ-024 SHALL instantiate one sub-module, uart_sync (2-flop synchronizer, reset value 1); everything else stays in uart_rx.

Verification (CLKS_PER_BIT=16 unless noted)
REQ-025 Drive 0xA5 at 16 cycles/bit -> exactly one rx_done pulse, data=0xA5, frame_err stays 0; rx_done at ~(2+8+128+16) cycles after the start edge.
REQ-026 Drive rx low for 4 cycles, then high -> no rx_done, no frame_err, FSM back in IDLE; a following 0x3C is received correctly.
REQ-027 Drive 0x3C with stop bit=0, line then held low 40 cycles -> one frame_err pulse, no rx_done, data keeps its prior value; the next 0x81 after the line goes high gives data=0x81.
REQ-028 Drive 0x00 then 0xFF back-to-back with no idle gap -> two rx_done pulses, data=0x00 then 0xFF.
REQ-029 Assert reset during data bit 3 of 0x55 -> no pulses, data=0x00; the following 0xC3 is received correctly.
REQ-030 Loop back from the team's transmitter at CLKS_PER_BIT=868 sending 0x5A, and separately drive rx at 3.5% fast baud with 0xF0 -> data=0x5A and data=0xF0, each with one rx_done pulse and no frame_err.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and standard bit-period constants
// used by both the receiver and the transmitter.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_9600   = 10417;
  localparam int unsigned CLKS_PER_BIT_115200 = 868;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_e;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle-high level.
module uart_sync (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-samples each bit of the synchronized line, reports good
// bytes with rx_done and bad stop bits with frame_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rx_done,
  output logic       frame_err
);

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_CNT = 16'((CLKS_PER_BIT / 2) - 1);

  logic       rxS;
  rx_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0] bitIdx_q, bitIdx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       rxDone_q, rxDone_d;
  logic       frameErr_q, frameErr_d;

  uart_sync uSync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rx),
    .q_o   (rxS)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      rxDone_q   <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      rxDone_q   <= rxDone_d;
      frameErr_q <= frameErr_d;
    end
  end

  // Counter saturates rather than wrapping, so a long idle never aliases a sample point.
  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    bitIdx_d   = bitIdx_q;
    shift_d    = shift_q;
    data_d     = data_q;
    rxDone_d   = 1'b0;
    frameErr_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rxS) begin
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d    = '0;
          bitIdx_d = '0;
          state_d  = rxS ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == LAST_CNT) begin
          shift_d[bitIdx_q] = rxS;
          cnt_d             = '0;
          bitIdx_d          = bitIdx_q + 3'd1;
          if (bitIdx_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (rxS) begin
            data_d   = shift_q;
            rxDone_d = 1'b1;
            state_d  = IDLE;
          end else begin
            frameErr_d = 1'b1;
            state_d    = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rxS) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign data      = data_q;
  assign rx_done   = rxDone_q;
  assign frame_err = frameErr_q;

endmodule
